// File: rtl/cla_pipe_pkg.sv
// Shared constants and the per-stage pipeline record for cla_pipe_adder.
// Operand and sum fields are sized for the widest legal adder; narrower builds use the low/high parts.
package cla_pipe_pkg;

  localparam int CHUNK_W = 4;
  localparam int MAX_W   = 64;

  // a/b hold the not-yet-consumed chunks right-aligned; s collects sum chunks entering from the top.
  typedef struct packed {
    logic             valid;
    logic             sub;
    logic             carry;
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
    logic [MAX_W-1:0] s;
  } stage_t;

endpackage

// File: rtl/cla_chunk.sv
// Combinational 4-bit carry-lookahead slice: sum, carry-out and group generate/propagate.
module cla_chunk
  import cla_pipe_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               c_in,
  output logic [CHUNK_W-1:0] sum,
  output logic               c_out,
  output logic               g,
  output logic               p
);

  logic [CHUNK_W-1:0] gen;
  logic [CHUNK_W-1:0] prop;
  logic [CHUNK_W-1:0] c;

  assign gen  = a & b;
  assign prop = a ^ b;

  assign c[0] = c_in;
  assign c[1] = gen[0] | (prop[0] & c_in);
  assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c_in);
  assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & c_in);

  assign g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
           | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign p = &prop;

  assign c_out = g | (p & c_in);
  assign sum   = prop ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/subtract, one 4-bit carry-lookahead chunk per stage, whole-pipe stall on backpressure.
// Optional ovf/zero flag outputs are built only when CLA_PIPE_FLAGS_EN is defined.
module cla_pipe_adder
  import cla_pipe_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef CLA_PIPE_FLAGS_EN
  output logic             ovf,
  output logic             zero,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int STAGES = WIDTH / CHUNK_W;
  localparam int LAST   = STAGES - 1;

  if ((WIDTH % CHUNK_W) != 0 || WIDTH < CHUNK_W || WIDTH > MAX_W) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 between 4 and 64");
  end

  // Handshake: a beat moves on a rising edge when valid & ready are both high on that side.
  // The whole pipe advances together, so in_ready never looks at in_valid.
  logic adv;

  assign adv      = out_ready | ~g_stage[LAST].q.valid;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t             src;
    stage_t             d;
    stage_t             q;
    logic [CHUNK_W-1:0] b_chunk;
    logic [CHUNK_W-1:0] s_chunk;
    logic               co;
    logic               grp_g;
    logic               grp_p;

    if (k == 0) begin : g_head
      always_comb begin
        src       = '0;
        src.valid = in_valid;
        src.sub   = sub;
        src.carry = sub | c_in;
        src.a     = MAX_W'(a);
        src.b     = MAX_W'(b);
      end
    end else begin : g_body
      assign src = g_stage[k-1].q;
    end

    // B travels uninverted; each stage applies the subtract inversion to its own chunk.
    assign b_chunk = src.b[CHUNK_W-1:0] ^ {CHUNK_W{src.sub}};

    cla_chunk u_chunk (
      .a     (src.a[CHUNK_W-1:0]),
      .b     (b_chunk),
      .c_in  (src.carry),
      .sum   (s_chunk),
      .c_out (co),
      .g     (grp_g),
      .p     (grp_p)
    );

    always_comb begin
      d       = src;
      d.carry = co;
      d.a     = src.a >> CHUNK_W;
      d.b     = src.b >> CHUNK_W;
      d.s     = (src.s >> CHUNK_W) | {s_chunk, {(MAX_W-CHUNK_W){1'b0}}};
      assert (co == (grp_g | (grp_p & src.carry)));
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if (adv) begin
        q <= d;
      end
    end
  end

  // After STAGES shifts the sum chunks sit in the top WIDTH bits of s.
  assign out_valid = g_stage[LAST].q.valid;
  assign c_out     = g_stage[LAST].q.carry;
  assign sum       = WIDTH'(g_stage[LAST].q.s >> (MAX_W - WIDTH));

`ifdef CLA_PIPE_FLAGS_EN
  logic             c_msb;
  logic [WIDTH-1:0] sum_d;

  assign c_msb = g_stage[LAST].s_chunk[CHUNK_W-1] ^ g_stage[LAST].src.a[CHUNK_W-1]
               ^ g_stage[LAST].b_chunk[CHUNK_W-1];
  assign sum_d = WIDTH'(g_stage[LAST].d.s >> (MAX_W - WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (adv) begin
      ovf  <= c_msb ^ g_stage[LAST].co;
      zero <= (sum_d == '0);
    end
  end
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: WIDTH=16 main instance plus a WIDTH=4 single-stage instance.
module tb_cla_pipe_adder;

  localparam int W = 16;
  localparam int LAT = W / 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, sub, c_in, out_valid, out_ready, c_out;
  logic [W-1:0] a, b, sum;
  logic         in_valid_n, in_ready_n, sub_n, c_in_n, out_valid_n, out_ready_n, c_out_n;
  logic [3:0]   a_n, b_n, sum_n;
`ifdef CLA_PIPE_FLAGS_EN
  logic ovf, zero, ovf_n, zero_n;
`endif

  cla_pipe_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef CLA_PIPE_FLAGS_EN
    .ovf(ovf), .zero(zero),
`endif
    .sum(sum), .c_out(c_out)
  );

  cla_pipe_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready_n),
    .a(a_n), .b(b_n), .sub(sub_n), .c_in(c_in_n),
    .out_valid(out_valid_n), .out_ready(out_ready_n),
`ifdef CLA_PIPE_FLAGS_EN
    .ovf(ovf_n), .zero(zero_n),
`endif
    .sum(sum_n), .c_out(c_out_n)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 0;      // 0 hold out_ready, 1 random, 2 stall on cycles 3..5
  int sched_cnt = 0;
  bit lat_mode = 1'b0;

  logic [W+2:0] exp_q[$];   // {ovf, zero, c_out, sum}
  int           acc_q[$];

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: plain integer arithmetic on a w-bit adder
  function automatic logic [66:0] model(int w, longint ux, longint uy, bit s, bit ci);
    longint m, half, r, sx, sy, sr;
    logic co, ov, zr;
    logic [63:0] sm;
    m    = longint'(1) << w;
    half = m >> 1;
    if (s) begin
      r  = ux - uy;
      co = (ux >= uy);
    end else begin
      r  = ux + uy + longint'(ci);
      co = (r >= m);
    end
    sm = 64'(r & (m - 1));
    sx = (ux >= half) ? ux - m : ux;
    sy = (uy >= half) ? uy - m : uy;
    sr = s ? sx - sy : sx + sy + longint'(ci);
    ov = (sr >= half) || (sr < -half);
    zr = (sm == 64'd0);
    return {ov, zr, co, sm};
  endfunction

  // driver tasks
  task automatic tick();
    @(negedge clk);
    sched_cnt++;
    if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    else if (mode == 2) out_ready = !(sched_cnt >= 3 && sched_cnt <= 5);
  endtask

  task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic s, logic ci);
    logic [66:0] m;
    int n;
    n = 0;
    a = x; b = y; sub = s; c_in = ci; in_valid = 1'b1;
    forever begin
      #1;
      if (in_ready) begin
        m = model(W, longint'(x), longint'(y), s, ci);
        exp_q.push_back({m[66:64], m[W-1:0]});
        acc_q.push_back(cyc);
        tick();
        break;
      end
      tick();
      n++;
      if (n > 100) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      tick();
      #3;
    end
    check("drain_left", 64'(exp_q.size()), 0);
  endtask

  // scoreboard monitor
  logic [W:0]   prev_out;
  bit           prev_stall = 1'b0;
  logic [W+2:0] e;
  int           t_acc;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
        if (out_ready) check("in_ready_go", in_ready, 1);
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", {c_out, sum}, prev_out);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e     = exp_q.pop_front();
            t_acc = acc_q.pop_front();
            check("sum", sum, e[W-1:0]);
            check("c_out", c_out, e[W]);
`ifdef CLA_PIPE_FLAGS_EN
            check("zero", zero, e[W+1]);
            check("ovf", ovf, e[W+2]);
`endif
            if (lat_mode) check("latency", 64'(cyc - t_acc), LAT);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {c_out, sum};
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  logic [66:0] m4;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; c_in = 1'b0; out_ready = 1'b1;
    in_valid_n = 1'b0; a_n = '0; b_n = '0; sub_n = 1'b0; c_in_n = 1'b0; out_ready_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
`ifdef CLA_PIPE_FLAGS_EN
    check("rst_flags", {ovf, zero}, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1);
    tick();

    // directed vectors, out_ready held high
    lat_mode = 1'b1;
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    send(16'h0000, 16'h0000, 1'b0, 1'b1);
    drain();
    lat_mode = 1'b0;

    // 8 back-to-back beats with a consumer stall
    tick();
    mode = 2;
    sched_cnt = 0;
    for (int i = 0; i < 8; i++)
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();

    // random traffic with random bubbles and backpressure
    mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    mode = 0;
    out_ready = 1'b1;
    drain();

    // reset with beats in flight
    tick();
    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_flight_out_valid", out_valid, 0);
    check("rst_flight_sum", sum, 0);
    exp_q.delete();
    acc_q.delete();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("in_ready_after_rst2", in_ready, 1);
    idle(6);
    lat_mode = 1'b1;
    send(16'hA5A5, 16'h1111, 1'b0, 1'b1);
    drain();
    lat_mode = 1'b0;

    // single-stage build
    tick();
    check("w4_idle_valid", out_valid_n, 0);
    in_valid_n = 1'b1; a_n = 4'h9; b_n = 4'h8; sub_n = 1'b0; c_in_n = 1'b0;
    #1;
    check("w4_in_ready", in_ready_n, 1);
    tick();
    in_valid_n = 1'b0;
    #2;
    check("w4_valid", out_valid_n, 1);
    check("w4_sum", sum_n, 4'h1);
    check("w4_c_out", c_out_n, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      in_valid_n = 1'b1;
      a_n = 4'($urandom); b_n = 4'($urandom);
      sub_n = 1'($urandom_range(0, 1)); c_in_n = 1'($urandom_range(0, 1));
      m4 = model(4, longint'(a_n), longint'(b_n), sub_n, c_in_n);
      tick();
      in_valid_n = 1'b0;
      #2;
      check("w4_rand_valid", out_valid_n, 1);
      check("w4_rand_out", {c_out_n, sum_n}, {m4[64], m4[3:0]});
`ifdef CLA_PIPE_FLAGS_EN
      check("w4_rand_flags", {ovf_n, zero_n}, {m4[66], m4[65]});
`endif
    end
    tick();
    #2;
    check("w4_bubble", out_valid_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
